elastic_pipe_reg: RTL and testbench
===================================

# elastic_pipe_reg

Parametrised elastic pipeline stage register. It replaces the fixed-field, enable/flush-only stage registers between pipeline stages (IF/ID through MEM/WB) with one generic block. It carries an opaque payload of WIDTH bits through a DEPTH-entry circular buffer using a valid/ready handshake, and adds synchronous flush and a sticky, program-terminating halt. Each pipeline stage boundary instantiates one copy, with the stage's field bundle packed into `in_data`.

## Interface
Parameters:
- WIDTH, 32: payload width in bits, 1..1024.
- DEPTH, 2: number of buffer entries, 1..8, must be a power of two.
- CNT_W, $clog2(DEPTH+1): occupancy counter width. Derived; do not override.

Ports:
- CLK  in  1  system clock; rising edge.
- nRST  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream offers an entry.
- in_ready  out  1  block can accept an entry this cycle.
- in_data  in  WIDTH  upstream payload.
- in_halt  in  1  the offered entry is a halt instruction.
- flush  in  1  synchronous discard of all buffered entries.
- out_valid  out  1  head entry is present.
- out_ready  in  1  downstream consumes the head entry.
- out_data  out  WIDTH  head-entry payload.
- out_halt  out  1  head entry carries the halt flag.
- halt  out  1  sticky; set when a halt entry is consumed.
- count  out  CNT_W  current occupancy, 0..DEPTH.

## Operation
- Push: in_valid && in_ready. Pop: out_valid && out_ready.
- Storage: DEPTH entries of {halt bit, WIDTH payload}. Write pointer and read pointer wrap modulo DEPTH.
- in_ready:
  - DEPTH>=2: in_ready = !full && !halt. It is registered-path only, with no combinational dependence on out_ready.
  - DEPTH=1: in_ready = (!full || out_ready) && !halt. This is pass-through, giving full throughput with one entry.
- out_valid = (count != 0) && !halt. out_data and out_halt are driven from the read-pointer entry. When empty they hold the last value; consumers must qualify them with out_valid.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Full, DEPTH>=2: push is blocked. A pop in the same cycle does not enable a push until the next cycle.
- Empty: a pop is impossible. Data pushed at cycle N appears at out_valid in cycle N+1. There is no bypass.
- flush:
  - Highest priority. At the next edge, count becomes 0 and both pointers become 0.
  - A push or pop in the same cycle is discarded.
  - flush does not clear halt.
- halt:
  - Set at the edge on which a pop occurs with out_halt=1.
  - Remains 1 until nRST.
  - While halt is 1: in_ready=0, out_valid=0, and the buffer freezes.
  - A halt entry that is flushed before it is popped does not set halt.
- Reset (nRST low, asynchronous): count=0, both pointers=0, halt=0, every entry payload=0, every entry halt bit=0.
- Outputs during and immediately after reset: out_valid=0, out_data=0, out_halt=0, in_ready=1.
- Reset asserted mid-transfer: all entries are lost and no pop is reported.

## Timing
- Latency: 1 cycle from push to out_valid.
- Throughput: 1 entry per cycle for every DEPTH, as long as downstream does not stall.
- Sustained throughput through downstream stalls: DEPTH>=2.
- count and halt are registered outputs.
- in_ready is combinational from out_ready only when DEPTH=1.
- No path from in_valid to out_valid within a single cycle.
- Counter arithmetic is unsigned, CNT_W bits. Pointers are $clog2(DEPTH) bits, or 1 bit when DEPTH=1, and wrap naturally.

## Structure
- Per-entry struct typedef {logic halt; logic [WIDTH-1:0] data} is local to the module because it is parametrised.
- Shared stage-payload typedefs (packed bundles of word_t, regbits_t, and the mux selection enums) go in data_path_muxs_pkg / cpu_types_pkg. Stages cast these to and from in_data/out_data.
- Sub-module pipe_ptr_ctr: parametrised wrap-around pointer with increment and synchronous clear, instantiated twice (read and write pointers).

## Test plan
- Reset, then push 0xDEADBEEF with WIDTH=32, DEPTH=2, out_ready=1 -> out_valid=1 and out_data=0xDEADBEEF one cycle later; count returns to 0.
- With out_ready=0, push 0x1, 0x2, 0x3 -> count=2 and in_ready=0 after two pushes; 0x3 is held off. Release out_ready -> outputs 0x1, 0x2, 0x3 in order; the pointers wrap.
- DEPTH=1, in_valid=out_ready=1 continuously for 8 cycles -> 8 pops in 8 cycles; count stays 1 after the first edge.
- Fill with 0xA, 0xB, then assert flush together with in_valid (0xC) -> count=0 next cycle, out_valid=0, and 0xC never emerges.
- Push 0x5, then 0x6 with in_halt=1, then 0x7 -> pop 0x5, then pop 0x6 sets halt next edge. After that, 0x7 is never output and in_ready=0 until nRST.
- Drop nRST asynchronously mid-cycle with count=2 -> out_valid, halt and count go to 0 immediately without a clock edge; in_ready=1.

Source files
------------

// File: rtl/elastic_pipe_reg_pkg.sv
// elastic_pipe_reg_pkg: shared types and helpers for the elastic pipeline stage register
package elastic_pipe_reg_pkg;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } op_e;

  function automatic int ptr_bits(input int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pipe_ptr_ctr.sv
// pipe_ptr_ctr: wrap-around buffer pointer with increment and synchronous clear
module pipe_ptr_ctr #(
  parameter int DEPTH = 2,
  parameter int W     = 1
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] ptr
);
  localparam logic [W-1:0] LAST = W'(DEPTH - 1);

  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) ptr <= '0;
    else if (clr) ptr <= '0;
    else if (inc) ptr <= ptr == LAST ? '0 : ptr + W'(1);
endmodule

// File: rtl/elastic_pipe_reg.sv
// elastic_pipe_reg: valid/ready stage register over a DEPTH-entry circular buffer
// with synchronous flush and a sticky halt that freezes the stage once a halt entry leaves.
module elastic_pipe_reg
  import elastic_pipe_reg_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_halt,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_halt,
  output logic             halt,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = ptr_bits(DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef struct packed {
    logic             halt;
    logic [WIDTH-1:0] data;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             full, push, pop;
  op_e              op;

  // Only a single-entry stage may look at out_ready; deeper stages keep in_ready registered-path.
  assign full      = count == FULL;
  assign in_ready  = !halt && (!full || (DEPTH == 1 && out_ready));
  assign out_valid = count != '0 && !halt;
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;
  assign op        = op_e'({push, pop});
  assign out_data  = head.data;
  assign out_halt  = head.halt;

  always_comb begin
    head = mem[0];
    for (int i = 1; i < DEPTH; i++)
      if (rd_ptr == PTR_W'(i)) head = mem[i];
  end

  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (push && wr_ptr == PTR_W'(i)) mem[i] <= '{halt: in_halt, data: in_data};
    end

  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      count <= '0;
      halt  <= 1'b0;
    end else begin
      count <= flush ? '0 :
               op == OP_PUSH ? count + CNT_W'(1) :
               op == OP_POP  ? count - CNT_W'(1) : count;
      if (pop && head.halt) halt <= 1'b1;
    end

  pipe_ptr_ctr #(.DEPTH(DEPTH), .W(PTR_W)) u_wr_ptr (
    .CLK(CLK), .nRST(nRST), .clr(flush), .inc(push), .ptr(wr_ptr)
  );

  pipe_ptr_ctr #(.DEPTH(DEPTH), .W(PTR_W)) u_rd_ptr (
    .CLK(CLK), .nRST(nRST), .clr(flush), .inc(pop), .ptr(rd_ptr)
  );
endmodule

// File: tb/tb_elastic_pipe_reg.sv
// tb_elastic_pipe_reg: DEPTH=1 and DEPTH=2 stages driven in lockstep, each checked against a queue model.
module tb_elastic_pipe_reg;
  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        iv = 1'b0, ih = 1'b0, fl = 1'b0, orr = 1'b0;
  logic [31:0] d = '0;
  logic        ir1, ov1, oh1, h1, ir2, ov2, oh2, h2;
  logic [31:0] od1, od2;
  logic [0:0]  c1;
  logic [1:0]  c2;
  int          n_chk = 0, n_err = 0, pops1 = 0;
  logic [32:0] q1[$], q2[$];
  bit          hm1 = 1'b0, hm2 = 1'b0;

  always #5 CLK = ~CLK;

  elastic_pipe_reg #(.WIDTH(32), .DEPTH(1)) u_d1 (
    .CLK(CLK), .nRST(nRST), .in_valid(iv), .in_ready(ir1), .in_data(d), .in_halt(ih),
    .flush(fl), .out_valid(ov1), .out_ready(orr), .out_data(od1), .out_halt(oh1),
    .halt(h1), .count(c1)
  );

  elastic_pipe_reg #(.WIDTH(32), .DEPTH(2)) u_d2 (
    .CLK(CLK), .nRST(nRST), .in_valid(iv), .in_ready(ir2), .in_data(d), .in_halt(ih),
    .flush(fl), .out_valid(ov2), .out_ready(orr), .out_data(od2), .out_halt(oh2),
    .halt(h2), .count(c2)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_model();
    q1.delete();
    q2.delete();
    hm1 = 1'b0;
    hm2 = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".d1_out_valid"}, ov1, 0);
    chk({tag, ".d1_out_data"}, od1, 0);
    chk({tag, ".d1_out_halt"}, oh1, 0);
    chk({tag, ".d1_in_ready"}, ir1, 1);
    chk({tag, ".d1_halt"}, h1, 0);
    chk({tag, ".d1_count"}, c1, 0);
    chk({tag, ".d2_out_valid"}, ov2, 0);
    chk({tag, ".d2_out_data"}, od2, 0);
    chk({tag, ".d2_out_halt"}, oh2, 0);
    chk({tag, ".d2_in_ready"}, ir2, 1);
    chk({tag, ".d2_halt"}, h2, 0);
    chk({tag, ".d2_count"}, c2, 0);
  endtask

  task automatic apply_reset();
    nRST = 1'b0;
    {iv, ih, fl, orr} = '0;
    d = '0;
    @(posedge CLK);
    @(negedge CLK);
    #1;
    check_reset_outputs("reset");
    nRST = 1'b1;
    clear_model();
  endtask

  task automatic step(input bit v, input logic [31:0] data, input bit hb, input bit f, input bit r);
    bit e_ir1, e_ov1, e_ir2, e_ov2;
    logic [32:0] hd1, hd2;
    @(negedge CLK);
    iv = v; d = data; ih = hb; fl = f; orr = r;
    #1;
    e_ir1 = !hm1 && (q1.size() < 1 || r);
    e_ov1 = q1.size() > 0 && !hm1;
    e_ir2 = !hm2 && q2.size() < 2;
    e_ov2 = q2.size() > 0 && !hm2;
    hd1 = q1.size() > 0 ? q1[0] : 33'h0;
    hd2 = q2.size() > 0 ? q2[0] : 33'h0;
    chk("d1.in_ready", ir1, e_ir1);
    chk("d1.out_valid", ov1, e_ov1);
    chk("d1.count", c1, q1.size());
    chk("d1.halt", h1, hm1);
    if (e_ov1) chk("d1.head", {oh1, od1}, hd1);
    chk("d2.in_ready", ir2, e_ir2);
    chk("d2.out_valid", ov2, e_ov2);
    chk("d2.count", c2, q2.size());
    chk("d2.halt", h2, hm2);
    if (e_ov2) chk("d2.head", {oh2, od2}, hd2);
    if (ov1 && r && !f) pops1++;
    @(posedge CLK);
    if (f) q1.delete();
    else begin
      if (e_ov1 && r) begin
        if (q1[0][32]) hm1 = 1'b1;
        void'(q1.pop_front());
      end
      if (v && e_ir1) q1.push_back({hb, data});
    end
    if (f) q2.delete();
    else begin
      if (e_ov2 && r) begin
        if (q2[0][32]) hm2 = 1'b1;
        void'(q2.pop_front());
      end
      if (v && e_ir2) q2.push_back({hb, data});
    end
  endtask

  initial begin
    apply_reset();

    // single push through an idle stage
    step(1, 32'hDEADBEEF, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("deadbeef_drained", c2, 0);

    // back-pressure then release, wrapping the pointers
    step(1, 32'h1, 0, 0, 0);
    step(1, 32'h2, 0, 0, 0);
    step(1, 32'h3, 0, 0, 0);
    chk("full_in_ready", ir2, 0);
    for (int i = 0; i < 5; i++) step(i < 2, 32'h3, 0, 0, 1);
    chk("wrap_drained", c2, 0);

    // single-entry pass-through throughput
    apply_reset();
    pops1 = 0;
    for (int i = 0; i < 9; i++) step(1, 32'h100 + i, 0, 0, 1);
    chk("d1_pops", pops1, 8);
    chk("d1_count_steady", c1, 1);

    // flush while offering another entry
    apply_reset();
    step(1, 32'hA, 0, 0, 0);
    step(1, 32'hB, 0, 0, 0);
    step(1, 32'hC, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    chk("flush_count", c2, 0);

    // sticky halt
    apply_reset();
    step(1, 32'h5, 0, 0, 0);
    step(1, 32'h6, 1, 0, 0);
    step(1, 32'h7, 0, 0, 1);
    for (int i = 0; i < 6; i++) step(1, 32'h7, 0, 0, 1);
    chk("halt_sticky", h2, 1);
    chk("halt_in_ready", ir2, 0);

    // asynchronous reset mid-cycle with a full stage
    apply_reset();
    step(1, 32'h11, 0, 0, 0);
    step(1, 32'h12, 0, 0, 0);
    #1;
    chk("pre_arst_count", c2, 2);
    #2;
    nRST = 1'b0;
    #1;
    check_reset_outputs("arst");
    @(negedge CLK);
    nRST = 1'b1;
    clear_model();

    // randomized traffic in short reset-separated segments
    for (int s = 0; s < 15; s++) begin
      apply_reset();
      for (int i = 0; i < 60; i++)
        step($urandom_range(3) != 0, $urandom(), $urandom_range(29) == 0,
             $urandom_range(19) == 0, $urandom_range(2) != 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
